// File: rtl/decode24_hold.sv
// -----------------------------------------------------------------------------
// decode24_hold
//   Registered 2-to-4 decoder with input qualification and output hold.
//   A code must be presented (en=1, unchanged) for STABLE_CNT cycles before it
//   is decoded onto dec. After en drops, the shown pattern is kept for
//   HOLD_CNT cycles and then cleared. Filters switch bounce and encoder
//   glitches ahead of the board's active-low LEDs.
//
// Parameters
//   STABLE_CNT : qualification cycles before dec updates (>= 2)
//   HOLD_CNT   : cycles dec is held after en deasserts   (>= 2)
//
// Ports
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset
//   en    in   code valid
//   code  in   [1:0] encoded index 0..3
//   dec   out  [3:0] registered one-hot decode (0000 = nothing shown)
//   led   out  [3:0] ~dec, for active-low LEDs
//   upd   out  one-cycle pulse in the cycle after dec changes
//   busy  out  high while qualifying a code
// -----------------------------------------------------------------------------
module decode24_hold #(
  parameter int STABLE_CNT = 16,
  parameter int HOLD_CNT   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] code,
  output logic [3:0] dec,
  output logic [3:0] led,
  output logic       upd,
  output logic       busy
);

  localparam int CNT_MAX = (STABLE_CNT > HOLD_CNT) ? STABLE_CNT : HOLD_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CNT - 1);

  typedef enum logic [1:0] {IDLE, QUAL, SHOW, HOLD} state_t;

  state_t           state_q, state_n;
  logic [1:0]       cap_q,   cap_n;
  logic [CNT_W-1:0] cnt_q,   cnt_n;
  logic [3:0]       dec_q,   dec_n;
  logic             upd_q;

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_n = state_q;
    cap_n   = cap_q;
    cnt_n   = cnt_q;
    dec_n   = dec_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_n = QUAL;
          cap_n   = code;
          cnt_n   = '0;
        end
      end

      QUAL: begin
        // en=0 takes priority over a simultaneous code change.
        if (!en) begin
          cnt_n   = '0;
          state_n = (dec_q != 4'b0000) ? HOLD : IDLE;
        end else if (code != cap_q) begin
          cap_n = code;
          cnt_n = '0;
        end else if (cnt_q == STABLE_LAST) begin
          dec_n   = 4'b0001 << cap_q;
          state_n = SHOW;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      SHOW: begin
        if (!en) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else if (code != cap_q) begin
          state_n = QUAL;
          cap_n   = code;
          cnt_n   = '0;
        end
      end

      HOLD: begin
        // A returning en beats the terminal count: the pattern is retained.
        if (en) begin
          state_n = QUAL;
          cap_n   = code;
          cnt_n   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          dec_n   = 4'b0000;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        dec_n   = 4'b0000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 4'b0000;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cap_q   <= cap_n;
      cnt_q   <= cnt_n;
      dec_q   <= dec_n;
      // Pulses only on a real value change; requalifying the same code
      // rewrites an identical pattern and stays silent.
      upd_q   <= (dec_n != dec_q);
    end
  end

  assign dec  = dec_q;
  assign led  = ~dec_q;
  assign upd  = upd_q;
  assign busy = (state_q == QUAL);

endmodule

// File: tb/tb_decode24_hold.sv
// -----------------------------------------------------------------------------
// tb_decode24_hold
//   Directed bench for decode24_hold with STABLE_CNT=4, HOLD_CNT=8.
//   Each step drives inputs on the falling edge, pushes the expected outputs
//   for the following rising edge into a scoreboard queue, and pops/compares
//   them 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_decode24_hold;

  localparam int STABLE_CNT = 4;
  localparam int HOLD_CNT   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] code;
  logic [3:0] dec;
  logic [3:0] led;
  logic       upd;
  logic       busy;

  decode24_hold #(
    .STABLE_CNT(STABLE_CNT),
    .HOLD_CNT  (HOLD_CNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .code (code),
    .dec  (dec),
    .led  (led),
    .upd  (upd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] dec;
    logic       upd;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [3:0] obs,
                       input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d,
                            input logic u, input logic b);
    exp_t e;
    e.tag  = tag;
    e.dec  = d;
    e.upd  = u;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".dec"},  dec,          e.dec);
      check({e.tag, ".led"},  led,          ~e.dec);
      check({e.tag, ".upd"},  {3'b0, upd},  {3'b0, e.upd});
      check({e.tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
    end
  endtask

  // One clock of stimulus with the outputs expected after that edge.
  task automatic step(input string tag, input logic e_in, input logic [1:0] c,
                      input logic [3:0] d, input logic u, input logic b);
    @(negedge clk);
    en   = e_in;
    code = c;
    expect_out(tag, d, u, b);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // Qualify code c from IDLE/SHOW/HOLD: STABLE_CNT busy cycles holding prev,
  // then exp shown (upd only when the pattern actually changes).
  task automatic show_code(input string tag, input logic [1:0] c,
                           input logic [3:0] prev, input logic [3:0] exp);
    for (int i = 0; i < STABLE_CNT; i++) step({tag, ".qual"}, 1'b1, c, prev, 1'b0, 1'b1);
    step({tag, ".show"}, 1'b1, c, exp, (prev != exp), 1'b0);
  endtask

  // Drop en: exp held for HOLD_CNT edges (H0..H0+7), cleared at H0+8.
  task automatic release_en(input string tag, input logic [1:0] c,
                            input logic [3:0] exp);
    for (int i = 0; i < HOLD_CNT; i++) step({tag, ".hold"}, 1'b0, c, exp, 1'b0, 1'b0);
    step({tag, ".clear"}, 1'b0, c, 4'b0000, 1'b1, 1'b0);
    step({tag, ".idle"},  1'b0, c, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    expect_out(tag, 4'b0000, 1'b0, 1'b0);
    compare_front();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    code  = 2'd0;
    #7;
    expect_out("por", 4'b0000, 1'b0, 1'b0);
    compare_front();
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

    // Basic decode of every code from IDLE, each released back to IDLE.
    show_code("c2", 2'd2, 4'b0000, 4'b0100);
    step("c2.stay", 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0);
    release_en("c2", 2'd2, 4'b0100);
    show_code("c0", 2'd0, 4'b0000, 4'b0001);
    release_en("c0", 2'd0, 4'b0001);
    show_code("c1", 2'd1, 4'b0000, 4'b0010);
    release_en("c1", 2'd1, 4'b0010);
    show_code("c3", 2'd3, 4'b0000, 4'b1000);

    // en returns at H0+5: same code requalifies, pattern kept, no upd.
    for (int i = 0; i < 5; i++) step("rehold", 1'b0, 2'd3, 4'b1000, 1'b0, 1'b0);
    show_code("requal", 2'd3, 4'b1000, 4'b1000);
    step("requal.stay", 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0);
    release_en("c3", 2'd3, 4'b1000);

    // Code change while shown: 0001 kept while busy, then 0100.
    show_code("chg0", 2'd0, 4'b0000, 4'b0001);
    show_code("chg2", 2'd2, 4'b0001, 4'b0100);
    release_en("chg2", 2'd2, 4'b0100);

    // Bounce 1->2->1 every two cycles, then hold 1.
    step("bounce1", 1'b1, 2'd1, 4'b0000, 1'b0, 1'b1);
    step("bounce1", 1'b1, 2'd1, 4'b0000, 1'b0, 1'b1);
    step("bounce2", 1'b1, 2'd2, 4'b0000, 1'b0, 1'b1);
    step("bounce2", 1'b1, 2'd2, 4'b0000, 1'b0, 1'b1);
    show_code("bounce", 2'd1, 4'b0000, 4'b0010);

    // HOLD -> QUAL, then en drops together with a code change: en=0 wins and
    // the full hold window restarts.
    for (int i = 0; i < 3; i++) step("hq.hold", 1'b0, 2'd1, 4'b0010, 1'b0, 1'b0);
    step("hq.qual", 1'b1, 2'd2, 4'b0010, 1'b0, 1'b1);
    step("hq.qual", 1'b1, 2'd2, 4'b0010, 1'b0, 1'b1);
    release_en("hq", 2'd3, 4'b0010);

    // Glitch from IDLE: never shows, returns to IDLE.
    step("glitch", 1'b1, 2'd1, 4'b0000, 1'b0, 1'b1);
    step("glitch", 1'b1, 2'd1, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("glitch.idle", 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0);

    // Async reset right after a show (upd high) and in mid-QUAL.
    show_code("rst", 2'd2, 4'b0000, 4'b0100);
    reset_check("rst.show");
    step("rst.idle", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
    step("rstq", 1'b1, 2'd3, 4'b0000, 1'b0, 1'b1);
    step("rstq", 1'b1, 2'd3, 4'b0000, 1'b0, 1'b1);
    reset_check("rst.qual");
    step("rst.idle2", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

    // Decoding still works after the mid-sequence reset.
    show_code("post", 2'd3, 4'b0000, 4'b1000);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode24_hold.md
# decode24_hold

Registered 2-to-4 decoder that turns a 2-bit code plus enable back into a one-hot LED pattern: the receiving end of the 4-to-2 switch encoder path. The code must stay stable for a programmable number of cycles before it is shown, filtering switch bounce and encoder glitches. After enable drops, the shown pattern is held for a programmable time. Sits between encoder/switch logic and the board's active-low LEDs.

## Interface
- STABLE_CNT, 16: cycles that en=1 with an unchanged code must persist before dec updates; legal range ≥2.
- HOLD_CNT, 50: cycles dec is held after en deasserts; legal range ≥2.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  code valid; synchronous to clk.
- code  input  2  encoded index 0..3.
- dec  output  4  registered one-hot decode, active-high; 4'b0000 = nothing shown.
- led  output  4  ~dec, driven from the same register for active-low LEDs.
- upd  output  1  one-cycle pulse in the cycle after dec changes value.
- busy  output  1  high while in QUAL.

## Operation
- Internal registers: state {IDLE, QUAL, SHOW, HOLD}, cap[1:0] (captured code), cnt (width $clog2(max(STABLE_CNT,HOLD_CNT))).
- IDLE: dec=0. If en=1, go to QUAL, cap<=code, cnt<=0.
- QUAL (dec keeps its prior value):
  - en=0: go to HOLD with cnt<=0 if dec≠0; otherwise go to IDLE.
  - en=1, code≠cap: cap<=code, cnt<=0 (restart qualification).
  - en=1, code==cap, cnt==STABLE_CNT-1: dec<=1<<cap, go to SHOW.
  - Otherwise cnt<=cnt+1.
- SHOW:
  - en=0: go to HOLD, cnt<=0.
  - en=1, code≠cap: go to QUAL, cap<=code, cnt<=0; dec unchanged.
  - en=1, code==cap: stay.
- HOLD:
  - en=1: go to QUAL, cap<=code, cnt<=0; dec unchanged.
  - Else if cnt==HOLD_CNT-1: dec<=0, go to IDLE.
  - Else cnt<=cnt+1.
- upd=1 for exactly one cycle whenever the dec register changes value, including the clear to 0 at the end of HOLD. Requalifying to the same code produces no pulse.
- busy = (state==QUAL).
- dec is always either one-hot or zero. Two bits are never set.

## Timing
- Reset (async assert, any time, including mid-QUAL or mid-HOLD): state=IDLE, dec=4'b0000, led=4'b1111, upd=0, busy=0, cap=0, cnt=0. Release is sampled at the next rising edge.
- Let E0 be the edge at which IDLE samples en=1. With en and code stable, dec updates at edge E0+STABLE_CNT and upd is high for the following cycle.
- Decode latency is therefore STABLE_CNT cycles from the first sampled en. A code change restarts the count from the edge that sees the change.
- Let H0 be the edge at which SHOW samples en=0. dec clears at edge H0+HOLD_CNT, provided en stays 0.
- en dropping in QUAL while dec≠0 restarts the full HOLD window.
- Simultaneous events:
  - HOLD with en=1 on the terminal count cycle: en wins. Go to QUAL, dec retained.
  - QUAL with en=0 and a code change in the same cycle: en=0 wins.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: STABLE_CNT=4, HOLD_CNT=8.
- Reset: rst_n=0 mid-sequence -> dec=0000, led=1111, upd=0 immediately, without waiting for a clock edge.
- Basic decode: en=1, code=2 from E0 -> dec=0100, led=1011 at E0+4, upd high one cycle. Repeat for codes 0, 1, 3 -> 0001, 0010, 1000.
- Bounce: en=1, code toggles 1→2→1 every 2 cycles, then holds 1 -> dec stays 0000 until 4 cycles after the last change, then 0010.
- Hold/release: after dec=1000, en=0 at H0 -> dec=1000 through H0+7, dec=0000 at H0+8 with an upd pulse. en=1 code=3 at H0+5 -> dec stays 1000, no upd, SHOW after 4 cycles.
- Code change while shown: dec=0001, en=1, code→2 -> busy for 4 cycles, dec remains 0001, then 0100 with an upd pulse.
- Glitch from idle: en=1 for 2 cycles, then 0 -> dec never leaves 0000, upd never asserts, returns to IDLE.
